// File: rtl/wb_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_mem_arbiter_pkg : shared encodings and defaults for the arbiter   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package wb_mem_arbiter_pkg;

   localparam int VIRTUAL_ADDR_LEN   = 39;
   localparam int DCACHE_WB_DATA_LEN = 64;
   localparam int ARB_TIMEOUT_CYCLES = 255;

   localparam logic ARB_M_ICACHE = 1'b0;
   localparam logic ARB_M_DCACHE = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_mem_arbiter_if : Wishbone classic port bundle with master/slave   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface wb_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 39,
   parameter int DATA_WIDTH = 64
);
   logic                      cyc;
   logic                      stb;
   logic                      we;
   logic [ADDR_WIDTH-1:0]     adr;
   logic [DATA_WIDTH-1:0]     dat_w;
   logic [DATA_WIDTH/8-1:0]   sel;
   logic                      ack;
   logic                      err;
   logic [DATA_WIDTH-1:0]     dat_r;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  ack, err, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output ack, err, dat_r
   );
endinterface
`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_watchdog : stb-without-ack counter with one-cycle err pulse   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module wb_arb_watchdog
   import wb_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   input  logic stb_i,
   input  logic ack_i,
   output logic err_o
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wdog_q;
   logic [CNT_W-1:0] wdog_d;
   logic             expire;

   // An ack on the terminal cycle suppresses the error.
   assign expire = active_i && stb_i && !ack_i &&
                   (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err_o  = expire;

   always_comb begin
      wdog_d = wdog_q;
      if (!active_i || !stb_i || ack_i || expire) begin
         wdog_d = '0;
      end else begin
         wdog_d = wdog_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_mem_arbiter : round-robin icache/dcache arbiter onto one WB slave |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = VIRTUAL_ADDR_LEN,
   parameter int DATA_WIDTH     = DCACHE_WB_DATA_LEN,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   wb_mem_arbiter_if.slave   m0,
   wb_mem_arbiter_if.slave   m1,
   wb_mem_arbiter_if.master  wb,
   output logic [1:0]        grant_o
);
   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       wd_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         last_q  <= ARB_M_DCACHE;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Ties go to whichever master did not own the previous grant.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (m0.cyc && (!m1.cyc || last_q == ARB_M_DCACHE)) begin
               state_d = ARB_GNT0;
               last_d  = ARB_M_ICACHE;
            end else if (m1.cyc) begin
               state_d = ARB_GNT1;
               last_d  = ARB_M_DCACHE;
            end
         end
         ARB_GNT0: if (!m0.cyc) state_d = ARB_IDLE;
         ARB_GNT1: if (!m1.cyc) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      wb.cyc   = 1'b0;
      wb.stb   = 1'b0;
      wb.we    = 1'b0;
      wb.adr   = {ADDR_WIDTH{1'b0}};
      wb.dat_w = {DATA_WIDTH{1'b0}};
      wb.sel   = {(DATA_WIDTH/8){1'b0}};
      m0.ack   = 1'b0;
      m0.dat_r = {DATA_WIDTH{1'b0}};
      m1.ack   = 1'b0;
      m1.dat_r = {DATA_WIDTH{1'b0}};
      case (state_q)
         ARB_GNT0: begin
            wb.cyc   = m0.cyc;
            wb.stb   = m0.stb;
            wb.we    = m0.we;
            wb.adr   = m0.adr;
            wb.dat_w = m0.dat_w;
            wb.sel   = m0.sel;
            m0.ack   = wb.ack;
            m0.dat_r = wb.dat_r;
         end
         ARB_GNT1: begin
            wb.cyc   = m1.cyc;
            wb.stb   = m1.stb;
            wb.we    = m1.we;
            wb.adr   = m1.adr;
            wb.dat_w = m1.dat_w;
            wb.sel   = m1.sel;
            m1.ack   = wb.ack;
            m1.dat_r = wb.dat_r;
         end
         default: ;
      endcase
   end

   wb_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .active_i (state_q != ARB_IDLE),
      .stb_i    (wb.stb),
      .ack_i    (wb.ack),
      .err_o    (wd_err)
   );

   assign m0.err  = (state_q == ARB_GNT0) && wd_err;
   assign m1.err  = (state_q == ARB_GNT1) && wd_err;
   assign grant_o = {state_q == ARB_GNT1, state_q == ARB_GNT0};
endmodule
`default_nettype wire
